// File: rtl/memory_fifo_controller.sv
// memory_fifo_controller: FIFO over a single-port async-read memory, one access per cycle plus a one-word output register
module memory_fifo_controller #(
    parameter int BITS              = 64,
    parameter int ADDRESS_BUS_WIDTH = 6
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         Flush,
    input  logic [BITS-1:0]              InData,
    input  logic                         InValid,
    output logic                         InReady,
    output logic [BITS-1:0]              OutData,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [BITS-1:0]              MemD,
    output logic [ADDRESS_BUS_WIDTH-1:0] MemAddress,
    output logic                         MemWE,
    input  logic [BITS-1:0]              MemQ,
    output logic [ADDRESS_BUS_WIDTH:0]   Level,
    output logic                         Empty,
    output logic                         Full
);
    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic            read_cycle, write_cycle;

    always_comb begin
        read_cycle  = level_q != '0 && (!out_valid_q || OutReady);
        // Reset_n gating drops InReady/MemWE immediately, aborting an in-flight write
        InReady     = !read_cycle && level_q != DEPTH && !Flush && Reset_n;
        write_cycle = InReady && InValid;
        wr_ptr_d    = Flush ? '0 : wr_ptr_q + AW'(write_cycle);
        rd_ptr_d    = Flush ? '0 : rd_ptr_q + AW'(read_cycle);
        level_d     = Flush ? '0 : level_q + (AW+1)'(write_cycle) - (AW+1)'(read_cycle);
        out_valid_d = Flush ? 1'b0 : read_cycle ? 1'b1 : out_valid_q && !OutReady;
        out_data_d  = Flush ? '0 : read_cycle ? MemQ : out_data_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign MemD       = InData;
    assign MemAddress = write_cycle ? wr_ptr_q : rd_ptr_q;
    assign MemWE      = write_cycle;
    assign OutData    = out_data_q;
    assign OutValid   = out_valid_q;
    assign Level      = level_q;
    assign Empty      = level_q == '0 && !out_valid_q;
    assign Full       = level_q == DEPTH;
endmodule

// File: tb/tb_memory_fifo_controller.sv
// tb_memory_fifo_controller: directed and random traffic against a queue-based reference model with a decoupled monitor
module tb_memory_fifo_controller;
    localparam int BITS = 8, AW = 2, DEPTH = 4;

    logic            Clock = 0, Reset_n = 0, Flush = 0, InValid = 0, OutReady = 0;
    logic [BITS-1:0] InData = '0;
    logic            InReady, OutValid, MemWE, Empty, Full;
    logic [BITS-1:0] OutData, MemD, MemQ;
    logic [AW-1:0]   MemAddress;
    logic [AW:0]     Level;

    logic [BITS-1:0] mem [DEPTH];
    logic [BITS-1:0] exp_q [$];
    int n_cmp = 0, n_err = 0;

    memory_fifo_controller #(.BITS(BITS), .ADDRESS_BUS_WIDTH(AW)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .MemD(MemD), .MemAddress(MemAddress), .MemWE(MemWE), .MemQ(MemQ),
        .Level(Level), .Empty(Empty), .Full(Full)
    );

    always #5 Clock = ~Clock;

    assign MemQ = mem[MemAddress];
    always @(posedge Clock) if (MemWE) mem[MemAddress] <= MemD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: predicts the next edge from the handshakes visible mid-cycle
    always @(negedge Clock) begin
        if (!Reset_n) begin
            check("rst_memwe", MemWE, 0);
            check("rst_inready", InReady, 0);
            check("rst_level", Level, 0);
            check("rst_outvalid", OutValid, 0);
            exp_q.delete();
        end else begin
            check("occupancy", 32'(Level) + 32'(OutValid), exp_q.size());
            check("empty", Empty, exp_q.size() == 0);
            check("full", Full, exp_q.size() == DEPTH + 1);
            if (Flush) begin
                check("flush_memwe", MemWE, 0);
                exp_q.delete();
            end else begin
                if (OutValid && OutReady) begin
                    check("pop_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("pop_data", OutData, exp_q.pop_front());
                end
                if (InValid && InReady) exp_q.push_back(InData);
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [BITS-1:0] v);
        bit ok = 0;
        InValid = 1;
        InData  = v;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge Clock);
            ok = InReady;
        end
        check("push_accept", ok, 1);
        step();
        InValid = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(posedge Clock);
        #1 Reset_n = 1;
        @(negedge Clock);
        check("init_empty", Empty, 1);
        check("init_full", Full, 0);
        check("init_inready", InReady, 1);
        check("init_outvalid", OutValid, 0);
        check("init_memwe", MemWE, 0);
        check("init_level", Level, 0);
        check("init_outdata", OutData, 0);

        step();
        InValid = 1;
        InData  = 8'hA1;
        @(negedge Clock);
        check("a1_write_we", MemWE, 1);
        check("a1_write_addr", MemAddress, 0);
        step();
        InValid = 0;
        @(negedge Clock);
        check("a1_read_we", MemWE, 0);
        check("a1_read_inready", InReady, 0);
        check("a1_read_addr", MemAddress, 0);
        step();
        @(negedge Clock);
        check("a1_outvalid", OutValid, 1);
        check("a1_outdata", OutData, 8'hA1);
        check("a1_level", Level, 0);
        check("a1_empty", Empty, 0);
        step();
        OutReady = 1;
        step();
        OutReady = 0;

        for (int v = 8'h10; v <= 8'h14; v++) push(8'(v));
        @(negedge Clock);
        check("fill_outdata", OutData, 8'h10);
        check("fill_level", Level, DEPTH);
        check("fill_full", Full, 1);
        check("fill_inready", InReady, 0);
        step();
        InValid = 1;
        InData  = 8'h15;
        @(negedge Clock);
        check("full_no_memwe", MemWE, 0);
        step();
        InValid  = 0;
        OutReady = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            @(negedge Clock);
            check("drain_valid", OutValid, 1);
            step();
        end
        @(negedge Clock);
        check("drain_empty", Empty, 1);
        step();

        InValid = 1;
        InData  = 0;
        for (int c = 0; c < 60 && InData < 10; c++) begin
            @(negedge Clock);
            check("cont_level_le1", Level <= 1, 1);
            acc = InReady;
            step();
            if (acc) InData++;
        end
        check("cont_all_accepted", InData, 10);
        InValid = 0;
        repeat (4) step();

        for (int c = 0; c < 500; c++) begin
            @(negedge Clock);
            acc = (InValid && InReady) || Flush;
            step();
            if (!InValid || acc) begin
                InValid = 1'($urandom_range(0, 1));
                InData  = 8'($urandom);
            end
            OutReady = $urandom_range(0, 3) < (((c / 100) % 2 == 1) ? 1 : 3);
            Flush    = $urandom_range(0, 39) == 0;
        end
        Flush    = 0;
        InValid  = 0;
        OutReady = 1;
        repeat (12) step();

        OutReady = 0;
        push(8'h21);
        push(8'h22);
        push(8'h23);
        @(negedge Clock);
        check("preflush_outvalid", OutValid, 1);
        check("preflush_level", Level, 2);
        step();
        Flush   = 1;
        InValid = 1;
        InData  = 8'h99;
        @(negedge Clock);
        check("flush_cycle_memwe", MemWE, 0);
        check("flush_cycle_inready", InReady, 0);
        step();
        Flush   = 0;
        InValid = 0;
        @(negedge Clock);
        check("postflush_level", Level, 0);
        check("postflush_outvalid", OutValid, 0);
        check("postflush_empty", Empty, 1);
        step();

        push(8'h31);
        push(8'h32);
        InValid = 1;
        InData  = 8'h33;
        @(negedge Clock);
        check("midwrite_memwe", MemWE, 1);
        check("midwrite_level", Level, 1);
        #2 Reset_n = 0;
        #1;
        check("abort_memwe", MemWE, 0);
        check("abort_level", Level, 0);
        check("abort_outvalid", OutValid, 0);
        step();
        step();
        InValid = 0;
        Reset_n = 1;
        @(negedge Clock);
        check("after_reset_level", Level, 0);
        check("after_reset_empty", Empty, 1);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
